// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, overflow flag and level interrupt.
// Responds on the data-memory bus inside a 32-byte word-aligned register window.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    input  logic        memRead,
    output logic [31:0] readData,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] SEL_CTRL     = 3'd0;
    localparam logic [2:0] SEL_PRESCALE = 3'd1;
    localparam logic [2:0] SEL_COUNT    = 3'd2;
    localparam logic [2:0] SEL_COMPARE  = 3'd3;
    localparam logic [2:0] SEL_STATUS   = 3'd4;

    logic [2:0]            ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q,  pre_cnt_d;
    logic [31:0]           count_q,    count_d;
    logic [31:0]           compare_q,  compare_d;
    logic [1:0]            status_q,   status_d;

    logic [2:0] sel;
    logic       wr_en;
    logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic       tick;
    logic       match_set, ovf_set;

    assign sel   = address[4:2];
    assign hit   = (address[31:5] == BASE_ADDR[31:5]) && (address[1:0] == 2'b00);
    assign wr_en = hit && memWrite;

    assign wr_ctrl     = wr_en && (sel == SEL_CTRL);
    assign wr_prescale = wr_en && (sel == SEL_PRESCALE);
    assign wr_count    = wr_en && (sel == SEL_COUNT);
    assign wr_compare  = wr_en && (sel == SEL_COMPARE);
    assign wr_status   = wr_en && (sel == SEL_STATUS);

    assign irq = ctrl_q[2] & status_q[0];

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        readData = 32'd0;
        if (hit && memRead) begin
            case (sel)
                SEL_CTRL:     readData = {29'd0, ctrl_q};
                SEL_PRESCALE: readData = 32'(prescale_q);
                SEL_COUNT:    readData = count_q;
                SEL_COMPARE:  readData = compare_q;
                SEL_STATUS:   readData = {30'd0, status_q};
                default:      readData = 32'd0;
            endcase
        end
    end

    // Reconfiguring CTRL or PRESCALE restarts the prescale period and suppresses that edge's tick.
    always_comb begin
        tick      = 1'b0;
        pre_cnt_d = pre_cnt_q;
        if (!ctrl_q[0] || wr_ctrl || wr_prescale) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q == prescale_q) begin
            pre_cnt_d = '0;
            tick      = 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ctrl_d     = wr_ctrl     ? writeData[2:0]            : ctrl_q;
        prescale_d = wr_prescale ? writeData[PRESCALE_W-1:0] : prescale_q;
        compare_d  = wr_compare  ? writeData                 : compare_q;
        count_d    = count_q;
        match_set  = 1'b0;
        ovf_set    = 1'b0;
        if (wr_count) begin
            count_d = writeData;
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                count_d   = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
            end else if (count_q == 32'hFFFF_FFFF) begin
                ovf_set = 1'b1;
                count_d = 32'd0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
        // Hardware set dominates a simultaneous write-1-clear.
        status_d = (status_q & ~(wr_status ? writeData[1:0] : 2'b00)) | {ovf_set, match_set};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            status_q   <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: bus accesses push expected hit/readData to a scoreboard
// queue, which is popped and compared once the combinational response has settled.
module tb_mmio_timer;

    localparam logic [31:0] A_CTRL     = 32'h0000_0400;
    localparam logic [31:0] A_PRESCALE = 32'h0000_0404;
    localparam logic [31:0] A_COUNT    = 32'h0000_0408;
    localparam logic [31:0] A_COMPARE  = 32'h0000_040C;
    localparam logic [31:0] A_STATUS   = 32'h0000_0410;

    typedef struct {
        string       tag;
        logic        hit;
        logic [31:0] rdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'd0;
    logic [31:0] writeData = 32'd0;
    logic        memWrite = 1'b0;
    logic        memRead = 1'b0;
    logic [31:0] readData;
    logic        hit;
    logic        irq;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    mmio_timer #(
        .BASE_ADDR (32'h0000_0400),
        .PRESCALE_W(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .writeData(writeData),
        .memWrite (memWrite),
        .memRead  (memRead),
        .readData (readData),
        .hit      (hit),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one bus access; a store holds its strobe through the next rising edge.
    task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr, input logic rd, input logic exp_hit,
                          input logic [31:0] exp_rdata);
        exp_t e;
        sb.push_back('{tag, exp_hit, exp_rdata});
        address   = addr;
        writeData = wdata;
        memWrite  = wr;
        memRead   = rd;
        #1;
        e = sb.pop_front();
        check({e.tag, ".hit"}, {31'd0, hit}, {31'd0, e.hit});
        check({e.tag, ".rdata"}, readData, e.rdata);
        if (wr) begin
            @(posedge clock);
            #1;
        end
        memWrite = 1'b0;
        memRead  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        access(tag, addr, data, 1'b1, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        access(tag, addr, 32'd0, 1'b0, 1'b1, 1'b1, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic irq_is(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        edges(2);
        reset = 1'b0;

        // Reset values across the whole window.
        rd("rst_ctrl",     A_CTRL,     32'd0);
        rd("rst_prescale", A_PRESCALE, 32'd0);
        rd("rst_count",    A_COUNT,    32'd0);
        rd("rst_compare",  A_COMPARE,  32'hFFFF_FFFF);
        irq_is("rst_irq", 1'b0);
        edges(1);
        rd("rst_status", A_STATUS,     32'd0);
        rd("rst_res14",  32'h0000_0414, 32'd0);
        rd("rst_res18",  32'h0000_0418, 32'd0);
        rd("rst_res1c",  32'h0000_041C, 32'd0);

        // Prescaled count with auto-reload and interrupt.
        wr("p3_prescale", A_PRESCALE, 32'd3);
        wr("p3_compare",  A_COMPARE,  32'd5);
        wr("p3_ctrl",     A_CTRL,     32'd7);
        rd("p3_ctrl_rb",  A_CTRL,     32'd7);
        edges(3);
        rd("p3_cnt_k3",   A_COUNT,    32'd0);
        edges(1);
        rd("p3_cnt_k4",   A_COUNT,    32'd1);
        edges(16);
        rd("p3_cnt_k20",  A_COUNT,    32'd5);
        rd("p3_stat_k20", A_STATUS,   32'd0);
        irq_is("p3_irq_k20", 1'b0);
        edges(4);
        rd("p3_stat_k24", A_STATUS,   32'd1);
        rd("p3_cnt_k24",  A_COUNT,    32'd0);
        irq_is("p3_irq_k24", 1'b1);
        wr("p3_clear",    A_STATUS,   32'd1);
        irq_is("p3_irq_clr", 1'b0);
        rd("p3_stat_clr", A_STATUS,   32'd0);

        // Match takes precedence over wrap.
        wr("w_ctrl0",    A_CTRL,     32'd0);
        wr("w_stclr",    A_STATUS,   32'd3);
        wr("w_prescale", A_PRESCALE, 32'd0);
        wr("w_compare",  A_COMPARE,  32'hFFFF_FFFF);
        wr("w_count",    A_COUNT,    32'hFFFF_FFFE);
        wr("w_en",       A_CTRL,     32'd1);
        rd("w_cnt_e0",   A_COUNT,    32'hFFFF_FFFE);
        edges(1);
        rd("w_cnt_e1",   A_COUNT,    32'hFFFF_FFFF);
        edges(1);
        rd("w_stat_e2",  A_STATUS,   32'd1);
        rd("w_cnt_e2",   A_COUNT,    32'd0);
        irq_is("w_irq_noen", 1'b0);

        // Wrap without match sets OVF; then set-wins over a same-edge clear.
        wr("o_ctrl0",   A_CTRL,    32'd0);
        wr("o_stclr",   A_STATUS,  32'd3);
        wr("o_compare", A_COMPARE, 32'd5);
        wr("o_count",   A_COUNT,   32'hFFFF_FFFE);
        wr("o_en",      A_CTRL,    32'd1);
        edges(2);
        rd("o_stat_e2", A_STATUS,  32'd2);
        rd("o_cnt_e2",  A_COUNT,   32'd0);
        edges(5);
        rd("o_cnt_e7",  A_COUNT,   32'd5);
        wr("o_clr_race", A_STATUS, 32'd1);
        rd("o_stat_race", A_STATUS, 32'd3);
        rd("o_cnt_e8",  A_COUNT,   32'd6);

        // CPU write to COUNT beats a same-edge tick.
        wr("c_ctrl0", A_CTRL,  32'd0);
        wr("c_en",    A_CTRL,  32'd1);
        wr("c_count", A_COUNT, 32'd100);
        rd("c_cnt0",  A_COUNT, 32'd100);
        edges(1);
        rd("c_cnt1",  A_COUNT, 32'd101);

        // Decode boundaries and read-during-write.
        wr("d_ctrl0", A_CTRL, 32'd0);
        access("d_st402", 32'h0000_0402, 32'd7,       1'b1, 1'b0, 1'b0, 32'd0);
        access("d_st40a", 32'h0000_040A, 32'h1234,    1'b1, 1'b0, 1'b0, 32'd0);
        access("d_ld402", 32'h0000_0402, 32'd0,       1'b0, 1'b1, 1'b0, 32'd0);
        access("d_ld500", 32'h0000_0500, 32'd0,       1'b0, 1'b1, 1'b0, 32'd0);
        access("d_st41c", 32'h0000_041C, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'd0);
        rd("d_ld41c",   32'h0000_041C, 32'd0);
        rd("d_ctrl_rb", A_CTRL,        32'd0);
        rd("d_cnt_rb",  A_COUNT,       32'd101);
        access("d_rmw", A_COMPARE, 32'd77, 1'b1, 1'b1, 1'b1, 32'd5);
        rd("d_cmp_rb",  A_COMPARE,     32'd77);

        // Reset mid-count.
        wr("r_count",    A_COUNT,    32'd37);
        wr("r_prescale", A_PRESCALE, 32'd2);
        wr("r_ctrl",     A_CTRL,     32'd5);
        rd("r_cnt_pre",  A_COUNT,    32'd37);
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        rd("r_cnt",      A_COUNT,    32'd0);
        rd("r_ctrl_rb",  A_CTRL,     32'd0);
        rd("r_compare",  A_COMPARE,  32'hFFFF_FFFF);
        rd("r_prescale_rb", A_PRESCALE, 32'd0);
        irq_is("r_irq", 1'b0);
        edges(5);
        rd("r_cnt_idle", A_COUNT,    32'd0);
        rd("r_stat",     A_STATUS,   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral on the processor's data-memory bus: address, writeData, memWrite, memRead, readData.
- The processor initiates loads and stores. This block is the responder and decodes one small register window.
- It holds a prescaled 32-bit up-counter with a compare register, a sticky match flag and an interrupt output.
- The top level muxes readData with data_memory using the hit output.

Parameters:
- BASE_ADDR, 32'h0000_0400: byte base address of the 32-byte register window. Bits [4:0] must be 0.
- PRESCALE_W, 16: width of the PRESCALE register and of the internal prescale counter.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- address  input  32  byte address from the ALU result
- writeData  input  32  store data (rt value)
- memWrite  input  1  store strobe
- memRead  input  1  load strobe
- readData  output  32  load data, combinational
- hit  output  1  address falls in the window and is word-aligned
- irq  output  1  interrupt request, level

Behaviour:
- Decode: hit = (address[31:5] == BASE_ADDR[31:5]) && (address[1:0] == 0). Register select is address[4:2].
- Misaligned accesses: hit=0, writes ignored, readData=0.
- Register map (byte offset):
  - 0x00 CTRL: R/W. bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 0x04 PRESCALE: R/W, PRESCALE_W bits, zero-extended on read.
  - 0x08 COUNT: R/W, 32 bits.
  - 0x0C COMPARE: R/W, 32 bits.
  - 0x10 STATUS: bit0 MATCH, bit1 OVF. Both sticky; write 1 to clear, write 0 has no effect.
  - 0x14-0x1C: reserved. Read 0, writes ignored.
- Reads: readData = (hit && memRead) ? selected register : 0. Pure combinational, zero latency, matching the single-cycle core.
- Writes: take effect at the rising edge where hit && memWrite. Byte enables are not supported; stores are full-word.
- Reset (reset=1 at an edge), all registers return to their reset values:
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, prescale counter=0.
  - Outputs: irq=0, hit and readData follow the inputs.
  - Reset mid-count aborts the count with no residual tick.
- Prescaler:
  - When EN=0, pre_cnt is held at 0 and no ticks occur.
  - When EN=1 at an edge: if pre_cnt==PRESCALE, then pre_cnt<=0 and a tick occurs; otherwise pre_cnt<=pre_cnt+1.
  - A tick occurs every PRESCALE+1 clocks. PRESCALE=0 gives a tick on every edge.
  - Any write to PRESCALE or CTRL forces pre_cnt<=0 at that edge.
  - No tick occurs on the edge of that write.
- Counting, evaluated on a tick edge:
  - If COUNT==COMPARE, MATCH<=1. COUNT<=0 if AUTO_RELOAD, else COUNT+1.
  - Else if COUNT==32'hFFFF_FFFF: COUNT<=0 and OVF<=1.
  - Else COUNT<=COUNT+1.
- Latency: EN written at edge k → first COUNT increment at edge k+PRESCALE+1.
- Simultaneous events:
  - CPU write to COUNT in the same edge as a tick: the write wins and the tick is dropped.
  - Hardware set of MATCH/OVF in the same edge as a write-1-clear: the set wins and the bit stays 1.
  - Write to COMPARE on a tick edge: compare uses the old COMPARE value.
  - memRead and memWrite both high: the write occurs at the edge and readData shows the pre-write value.
- irq = CTRL.IRQ_EN & STATUS.MATCH. It is derived only from registers, so it is glitch-free. It deasserts the edge after MATCH is cleared.
- Implementation is a flat register file plus the prescaler/counter datapath. There is no FSM beyond pre_cnt. Target 150-250 lines.

Test Plan:
- Reset → all reads of 0x400..0x41C return 0, except 0x40C which returns 0xFFFF_FFFF; irq=0, hit=1 for each aligned address.
- Write PRESCALE=3, COMPARE=5, CTRL=7 (edge k) → COUNT=1 at edge k+4, COUNT=5 at edge k+20; at edge k+24, STATUS=1, COUNT=0 and irq=1. Write STATUS=1 → irq=0 on the next edge.
- PRESCALE=0, COMPARE=0xFFFF_FFFF, AUTO_RELOAD=0, COUNT written 0xFFFF_FFFE, EN=1 → COUNT=0xFFFF_FFFF next edge. The following edge sets MATCH; COUNT becomes 0 with OVF=0 because the match path takes precedence. With COMPARE=5 instead, the wrap sets OVF=1 and MATCH stays 0.
- PRESCALE=0, EN=1, write COUNT=100 on an edge → COUNT=100, not 101. Next edge gives 101.
- Address 0x402 store, address 0x500 load, address 0x41C store → hit=0, 0, 1; no register change; readData=0 in all cases.
- Assert reset while COUNT=37, EN=1 → the next edge gives COUNT=0, CTRL=0, irq=0, and there are no ticks afterwards.
